ds_decoder: RTL and testbench

//  Receive-side counterpart of the deltasigma modulator. Samples the 1-bit stream d_in
//  (deltasigma out, or twister d_out) on each next strobe and counts ones over a window
//  of 2**BITS samples to recover the modulator's input code.

---
 rtl/ds_decoder.sv | 107 ++++++++++
 tb/tb_ds_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ds_decoder.sv
// Delta-sigma bitstream decoder: counts ones over 2**BITS strobed samples,
// reports each window result and tracks lock on consecutive agreeing results.
module ds_decoder #(
  parameter int unsigned BITS     = 5,
  parameter int unsigned LOCK_TOL = 0,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_in,
  input  logic            next,
  input  logic            clear,
  output logic [BITS:0]   data_out,
  output logic            data_valid,
  output logic            locked,
  output logic            overrun
);

  localparam int unsigned OW = BITS + 1;
  localparam int unsigned DW = BITS + 2;
  localparam int unsigned AW = $clog2(LOCK_CNT + 1);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] cnt;
  logic [OW-1:0]   acc;
  logic [OW-1:0]   prev, prev_nxt;
  logic [AW-1:0]   agree, agree_nxt;
  logic            locked_nxt;

  logic            take_c;
  logic            done_c;
  logic [OW-1:0]   result_c;
  logic [DW-1:0]   diff_c;
  logic [DW-1:0]   mag_c;

  // clear wins over a coincident strobe, which also cancels a window completion
  assign take_c   = next & ~clear;
  assign done_c   = take_c & (cnt == {BITS{1'b1}});
  assign result_c = acc + OW'(d_in);
  assign diff_c   = DW'(result_c) - DW'(prev);
  assign mag_c    = diff_c[DW-1] ? (DW'(0) - diff_c) : diff_c;

  // Sample counter, ones accumulator and result reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= done_c;
      overrun    <= overrun | (next & data_valid);
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (take_c) begin
        cnt <= cnt + BITS'(1);
        acc <= done_c ? '0 : result_c;
      end
      if (done_c) begin
        data_out <= result_c;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACQ;
      prev   <= '0;
      agree  <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      prev   <= prev_nxt;
      agree  <= agree_nxt;
      locked <= locked_nxt;
    end
  end

  // Lock FSM next state, evaluated only when a window result is produced
  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev;
    agree_nxt  = agree;
    locked_nxt = locked;
    if (done_c) begin
      prev_nxt = result_c;
      if (state == ACQ) begin
        state_nxt  = TRACK;
        locked_nxt = 1'b0;
      end else if (mag_c <= DW'(LOCK_TOL)) begin
        if (agree != AW'(LOCK_CNT)) begin
          agree_nxt = agree + AW'(1);
        end
        locked_nxt = (agree >= AW'(LOCK_CNT - 1));
      end else begin
        agree_nxt  = '0;
        locked_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds_decoder.sv
// Directed bench for ds_decoder: window table plus reset, clear and
// continuous-strobe sequences; two instances differ only in LOCK_TOL.
module tb_ds_decoder;

  logic       clk = 1'b0;
  logic       rst, d_in, next, clear;
  logic [5:0] data_out0, data_out4;
  logic       data_valid0, data_valid4;
  logic       locked0, locked4;
  logic       overrun0, overrun4;

  int n_pass = 0;
  int n_total = 0;
  int sacc;

  always #5 clk = ~clk;

  ds_decoder #(.BITS(5), .LOCK_TOL(0), .LOCK_CNT(2)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .next(next), .clear(clear),
    .data_out(data_out0), .data_valid(data_valid0), .locked(locked0), .overrun(overrun0)
  );

  ds_decoder #(.BITS(5), .LOCK_TOL(4), .LOCK_CNT(2)) dut4 (
    .clk(clk), .rst(rst), .d_in(d_in), .next(next), .clear(clear),
    .data_out(data_out4), .data_valid(data_valid4), .locked(locked4), .overrun(overrun4)
  );

  typedef struct {
    int code;
    int gap;
    int exp_out;
    int exp_lock0;
    int exp_lock4;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // First-order modulator model: emits exactly `code` ones per 32 samples
  function automatic logic ds_bit(input int code);
    int sum;
    logic b;
    sum  = sacc + code;
    b    = (sum >= 32);
    sacc = b ? sum - 32 : sum;
    return b;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next = 1'b0;
      d_in = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic strobe(input logic b, input logic clr);
    next  = 1'b1;
    d_in  = b;
    clear = clr;
    @(posedge clk); #1;
    next  = 1'b0;
    clear = 1'b0;
    d_in  = 1'($urandom);
  endtask

  // n strobes of constant value; returns 1 if data_valid rose early
  task automatic strobes(input int n, input logic b, output logic early);
    early = 1'b0;
    for (int i = 0; i < n; i++) begin
      strobe(b, 1'b0);
      if (data_valid0) early = 1'b1;
    end
  endtask

  initial begin
    logic early;
    int   vcount;

    vecs[0] = '{16, 4, 16, 0, 0};
    vecs[1] = '{16, 4, 16, 0, 0};
    vecs[2] = '{16, 4, 16, 1, 1};
    vecs[3] = '{ 0, 1,  0, 0, 0};
    vecs[4] = '{32, 1, 32, 0, 0};
    vecs[5] = '{16, 2, 16, 0, 0};
    vecs[6] = '{16, 1, 16, 0, 0};
    vecs[7] = '{16, 3, 16, 1, 1};
    vecs[8] = '{20, 1, 20, 0, 1};
    vecs[9] = '{ 7, 1,  7, 0, 0};

    rst = 1'b1; next = 1'b0; clear = 1'b0; d_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", int'(data_out0), 0);
    check("rst_valid", int'(data_valid0), 0);
    check("rst_locked", int'(locked0), 0);
    check("rst_overrun", int'(overrun0), 0);
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      sacc  = 0;
      early = 1'b0;
      for (int i = 0; i < 32; i++) begin
        idle(vecs[r].gap - 1);
        strobe(ds_bit(vecs[r].code), 1'b0);
        if (i < 31 && data_valid0) early = 1'b1;
      end
      check($sformatf("v%0d_early_valid", r), int'(early), 0);
      check($sformatf("v%0d_valid", r), int'(data_valid0), 1);
      check($sformatf("v%0d_data_out", r), int'(data_out0), vecs[r].exp_out);
      check($sformatf("v%0d_locked_tol0", r), int'(locked0), vecs[r].exp_lock0);
      check($sformatf("v%0d_locked_tol4", r), int'(locked4), vecs[r].exp_lock4);
      check($sformatf("v%0d_overrun", r), int'(overrun0), 0);
      idle(1);
      check($sformatf("v%0d_valid_pulse", r), int'(data_valid0), 0);
    end

    // Reset mid-window discards partial counts
    strobes(10, 1'b1, early);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_data_out", int'(data_out0), 0);
    check("midrst_valid", int'(data_valid0), 0);
    check("midrst_locked4", int'(locked4), 0);
    check("midrst_overrun", int'(overrun0), 0);
    rst = 1'b0;
    strobes(31, 1'b0, early);
    check("postrst_early", int'(early), 0);
    strobe(1'b0, 1'b0);
    check("postrst_valid", int'(data_valid0), 1);
    check("postrst_data_out", int'(data_out0), 0);
    idle(1);

    // clear on the 5th strobe drops it and restarts the window
    strobes(4, 1'b1, early);
    strobe(1'b1, 1'b1);
    strobes(31, 1'b1, early);
    check("clear_early", int'(early), 0);
    strobe(1'b1, 1'b0);
    check("clear_valid", int'(data_valid0), 1);
    check("clear_data_out", int'(data_out0), 32);
    idle(1);

    // clear in the completion cycle suppresses the result
    strobes(31, 1'b0, early);
    strobe(1'b0, 1'b1);
    check("clrdone_valid", int'(data_valid0), 0);
    check("clrdone_data_out", int'(data_out0), 32);
    strobes(31, 1'b0, early);
    check("clrdone_early", int'(early), 0);
    strobe(1'b0, 1'b0);
    check("clrdone_next_valid", int'(data_valid0), 1);
    check("clrdone_next_data", int'(data_out0), 0);
    idle(1);

    // next tied high for two windows: ones, then modulated code 16
    check("cont_overrun_pre", int'(overrun0), 0);
    vcount = 0;
    sacc = 0;
    next = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      d_in = (c <= 32) ? 1'b1 : ds_bit(16);
      @(posedge clk); #1;
      if (c == 32) begin
        check("cont_valid1", int'(data_valid0), 1);
        check("cont_data1", int'(data_out0), 32);
      end else if (c == 33) begin
        check("cont_overrun_set", int'(overrun0), 1);
        check("cont_valid1_pulse", int'(data_valid0), 0);
      end else if (c == 64) begin
        check("cont_valid2", int'(data_valid0), 1);
        check("cont_data2", int'(data_out0), 16);
      end else if (data_valid0) begin
        vcount++;
      end
    end
    next = 1'b0;
    check("cont_stray_valid", vcount, 0);
    idle(5);
    check("cont_overrun_sticky", int'(overrun0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("cont_overrun_rst", int'(overrun0), 0);
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
